// File: rtl/shift_pkg.sv
// Shared types and constants for the parallel-to-serial transmitter.
package shift_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_tx.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word and shifts it out
// one bit per cycle, with back-to-back acceptance on the last bit.
module shift_tx
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;

  logic             last;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shifted;

  // Last bit of the word in flight is on sout while the counter reads zero.
  assign last       = (state == SHIFT) && (cnt == '0);
  assign load_ready = (state == IDLE) || last;
  assign accept     = load_valid && load_ready;

  // Output-end selection depends on bit order; shreg keeps the unsent tail.
  assign first_bit = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign next_bit  = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
  assign shifted   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  // FSM, shift register, down counter and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
    end else if (accept) begin
      state      <= SHIFT;
      shreg      <= load_data;
      cnt        <= CNT_W'(WIDTH - 1);
      sout       <= first_bit;
      sout_valid <= 1'b1;
      done       <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          if (cnt != '0) begin
            shreg      <= shifted;
            cnt        <= cnt - CNT_W'(1);
            sout       <= next_bit;
            sout_valid <= 1'b1;
            done       <= (cnt == CNT_W'(1));
          end else begin
            state      <= IDLE;
            shreg      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_tx.sv
// Bench for shift_tx: queue-based reference model checked every cycle, plus
// directed sequences with hand-computed literal expectations.
module tb_shift_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       lv_m, lv_l;
  logic [3:0] ld_m, ld_l;
  logic       rdy_m, so_m, sv_m, dn_m;
  logic       rdy_l, so_l, sv_l, dn_l;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .load_data(ld_m), .load_valid(lv_m),
    .load_ready(rdy_m), .sout(so_m), .sout_valid(sv_m), .done(dn_m)
  );

  shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load_data(ld_l), .load_valid(lv_l),
    .load_ready(rdy_l), .sout(so_l), .sout_valid(sv_l), .done(dn_l)
  );

  // Serial-in parallel-out receiver looped back from the MSB-first stream.
  logic       n_rst;
  logic [3:0] q;
  assign n_rst = ~rst;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) q <= 4'b0000;
    else if (sv_m) q <= {q[2:0], so_m};
  end

  // Reference model: queue of bits still to appear on sout, head = current bit.
  bit qm[$];
  bit ql[$];

  always @(posedge clk) begin
    bit rm, rl;
    rm = (qm.size() <= 1);
    rl = (ql.size() <= 1);
    if (rst) begin
      qm.delete();
      ql.delete();
    end else begin
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (lv_m && rm) for (int i = 3; i >= 0; i--) qm.push_back(ld_m[i]);
      if (lv_l && rl) for (int i = 0; i <= 3; i++) ql.push_back(ld_l[i]);
    end
  end

  function automatic logic [3:0] model_vec(input bit bq[$]);
    if (bq.size() == 0) return 4'b1000;
    return {bq.size() <= 1, 1'b1, bq[0], bq.size() == 1};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Captured {load_ready, sout_valid, sout, done} per cycle for directed checks.
  logic [3:0] cap_m[$];
  logic [3:0] cap_l[$];

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      cap_m.push_back({rdy_m, sv_m, so_m, dn_m});
      cap_l.push_back({rdy_l, sv_l, so_l, dn_l});
      check("model_msb", 16'({rdy_m, sv_m, so_m, dn_m}), 16'(model_vec(qm)));
      check("model_lsb", 16'({rdy_l, sv_l, so_l, dn_l}), 16'(model_vec(ql)));
    end
  end

  // Field b of n captured cycles from start, first cycle in the MSB position.
  function automatic logic [15:0] field(input logic [3:0] cq[$], input int start,
                                        input int n, input int b);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[n-1-i] = cq[start+i][b];
    return r;
  endfunction

  localparam int B_RDY = 3;
  localparam int B_VLD = 2;
  localparam int B_SO  = 1;
  localparam int B_DN  = 0;

  task automatic step(input logic r, input logic vm, input logic [3:0] dm,
                      input logic vl, input logic [3:0] dl);
    rst  = r;
    lv_m = vm;
    ld_m = dm;
    lv_l = vl;
    ld_l = dl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
  endtask

  initial begin
    int s;
    rst  = 1'b1;
    lv_m = 1'b0; ld_m = 4'h0;
    lv_l = 1'b0; ld_l = 4'h0;
    step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'hF, 1'b1, 4'hF);
    chk_en = 1'b1;
    check("reset_msb", 16'({rdy_m, sv_m, so_m, dn_m}), 16'h0008);
    check("reset_lsb", 16'({rdy_l, sv_l, so_l, dn_l}), 16'h0008);
    idle(1);

    // Single word 1011 from idle, then loopback receiver contents.
    step(1'b0, 1'b1, 4'b1011, 1'b0, 4'h0);
    s = cap_m.size();
    idle(4);
    check("sipo_q", 16'(q), 16'h000B);
    idle(1);
    check("w1_sout", field(cap_m, s, 5, B_SO),  16'b10110);
    check("w1_vld",  field(cap_m, s, 5, B_VLD), 16'b11110);
    check("w1_done", field(cap_m, s, 5, B_DN),  16'b00010);
    check("w1_rdy",  field(cap_m, s, 5, B_RDY), 16'b00011);

    // Back-to-back 1011 then 0110, second accepted on the last bit.
    step(1'b0, 1'b1, 4'b1011, 1'b0, 4'h0);
    s = cap_m.size();
    idle(3);
    step(1'b0, 1'b1, 4'b0110, 1'b0, 4'h0);
    idle(5);
    check("b2b_sout", field(cap_m, s, 9, B_SO),  16'b110110110 & 16'b101101100 | 16'b101101100);
    check("b2b_vld",  field(cap_m, s, 9, B_VLD), 16'b111111110);
    check("b2b_done", field(cap_m, s, 9, B_DN),  16'b000100010);

    // Word 0001 with 1111 held early: ignored until the last bit.
    step(1'b0, 1'b1, 4'b0001, 1'b0, 4'h0);
    s = cap_m.size();
    idle(1);
    step(1'b0, 1'b1, 4'b1111, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'b1111, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'b1111, 1'b0, 4'h0);
    idle(5);
    check("hold_sout", field(cap_m, s, 9, B_SO),  16'b000111110);
    check("hold_done", field(cap_m, s, 9, B_DN),  16'b000100010);
    check("hold_rdy",  field(cap_m, s, 9, B_RDY), 16'b000100011);

    // Reset mid-word aborts with no done pulse.
    step(1'b0, 1'b1, 4'b1010, 1'b0, 4'h0);
    s = cap_m.size();
    idle(1);
    step(1'b1, 1'b1, 4'b1111, 1'b0, 4'h0);
    idle(2);
    check("rst_sout", field(cap_m, s, 4, B_SO),  16'b1000);
    check("rst_vld",  field(cap_m, s, 4, B_VLD), 16'b1100);
    check("rst_done", field(cap_m, s, 4, B_DN),  16'b0000);
    check("rst_rdy",  field(cap_m, s, 4, B_RDY), 16'b0011);

    // Reset wins over a simultaneous accept.
    step(1'b1, 1'b1, 4'b1111, 1'b1, 4'b1111);
    s = cap_m.size();
    idle(1);
    check("rst_prio", 16'({cap_m[s], cap_l[s]}), 16'h0088);

    // LSB-first word 1101.
    step(1'b0, 1'b0, 4'h0, 1'b1, 4'b1101);
    s = cap_l.size();
    idle(5);
    check("lsb_sout", field(cap_l, s, 5, B_SO),  16'b10110);
    check("lsb_vld",  field(cap_l, s, 5, B_VLD), 16'b11110);
    check("lsb_done", field(cap_l, s, 5, B_DN),  16'b00010);

    // Randomized traffic with occasional reset, checked by the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 2) != 0), 4'($urandom),
           ($urandom_range(0, 3) == 0), 4'($urandom));
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
